// File: rtl/calc_rx_pkg.sv
// Shared types and defaults for the calculator result receiver.
package calc_rx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      TAIL = 2'd2
   } rx_state_e;

   localparam int SIZE_DEF        = 4;
   localparam int WORD_W_DEF      = 16;
   localparam int TIMEOUT_CYC_DEF = 1024;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clktx_edge_det.sv
// Registers the calculator's ClkTx strobe and produces a one-cycle beat
// pulse on its rising edge, gated by the receiver enable.
module clktx_edge_det (
   input  logic Clk,
   input  logic Reset,
   input  logic RxEn,
   input  logic ClkTx,
   output logic beat
);

   logic clktx_q;
   logic clktx_d;

   assign clktx_d = ClkTx;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) clktx_q <= 1'b0;
      else        clktx_q <= clktx_d;
   end

   assign beat = RxEn & ClkTx & ~clktx_q;

endmodule

// File: rtl/calc_result_receiver.sv
// Reassembles SIZE-bit serial beats from the calculator into WORD_W-bit
// results and presents them on a valid/ready holding register.
//
// state | meaning
// IDLE  | waiting for the first qualified beat of a frame
// RECV  | mid-frame, collecting beats; inter-beat timer running
// TAIL  | word complete, waiting for DoutValid to be sampled low
module calc_result_receiver
   import calc_rx_pkg::*;
#(
   parameter int SIZE        = SIZE_DEF,
   parameter int WORD_W      = WORD_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              RxEn,
   input  logic              DoutValid,
   input  logic [SIZE-1:0]   DataOut,
   input  logic              ClkTx,
   output logic [WORD_W-1:0] Result,
   output logic              ResultValid,
   input  logic              ResultReady,
   output logic              FrameErr,
   output logic              Overrun,
   output logic [15:0]       FrameCnt,
   output logic [7:0]        ErrCnt
);

   localparam int NUM_BEATS = WORD_W / SIZE;
   localparam int CNT_W     = cnt_w(NUM_BEATS);
   localparam int TMR_W     = cnt_w(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BEATS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   logic beat;

   clktx_edge_det u_edge (
      .Clk   (Clk),
      .Reset (Reset),
      .RxEn  (RxEn),
      .ClkTx (ClkTx),
      .beat  (beat)
   );

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              long_err_q, long_err_d;
   logic [WORD_W-1:0] result_q, result_d;
   logic              valid_q, valid_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [WORD_W-1:0] shreg_shift;
   logic [8:0]        err_sum;
   logic              complete;

   // The completing beat's data goes straight into Result, so the word is
   // visible one Clk after the last ClkTx-rise sample.
   assign shreg_shift = (shreg_q << SIZE) | WORD_W'(DataOut);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      timer_d     = '0;
      long_err_d  = long_err_q;
      frame_err_d = 1'b0;
      complete    = 1'b0;

      if (!RxEn) begin
         state_d    = IDLE;
         cnt_d      = '0;
         long_err_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (beat && DoutValid) begin
                  shreg_d = shreg_shift;
                  if (NUM_BEATS == 1) begin
                     complete = 1'b1;
                     cnt_d    = '0;
                     state_d  = TAIL;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     state_d = RECV;
                  end
               end
            end
            RECV: begin
               if (beat) begin
                  if (DoutValid) begin
                     shreg_d = shreg_shift;
                     if (cnt_q == CNT_LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = TAIL;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end else begin
                     frame_err_d = 1'b1;
                     cnt_d       = '0;
                     state_d     = IDLE;
                  end
               end else if (timer_q == TMR_LAST) begin
                  frame_err_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = IDLE;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            TAIL: begin
               if (beat) begin
                  if (!DoutValid) begin
                     long_err_d = 1'b0;
                     state_d    = IDLE;
                  end else if (!long_err_q) begin
                     frame_err_d = 1'b1;
                     long_err_d  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Holding register: a completion while a word is pending and not being
   // accepted is dropped and flagged; accept-and-complete hands over cleanly.
   always_comb begin
      result_d    = result_q;
      valid_d     = valid_q;
      overrun_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;

      if (complete) begin
         if (!valid_q || ResultReady) begin
            result_d    = shreg_shift;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ResultReady) begin
         valid_d = 1'b0;
      end

      err_sum   = {1'b0, err_cnt_q} + 9'(frame_err_d) + 9'(overrun_d);
      err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         timer_q     <= '0;
         long_err_q  <= 1'b0;
         result_q    <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         timer_q     <= timer_d;
         long_err_q  <= long_err_d;
         result_q    <= result_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign Result      = result_q;
   assign ResultValid = valid_q;
   assign FrameErr    = frame_err_q;
   assign Overrun     = overrun_q;
   assign FrameCnt    = frame_cnt_q;
   assign ErrCnt      = err_cnt_q;

endmodule

// File: tb/tb_calc_result_receiver.sv
// Directed bench for calc_result_receiver: framing, backpressure, errors,
// timeout, enable and reset behaviour with hand-computed expectations.
module tb_calc_result_receiver;

   logic        Clk;
   logic        Reset;
   logic        RxEn;
   logic        DoutValid;
   logic [3:0]  DataOut;
   logic        ClkTx;
   logic [15:0] Result;
   logic        ResultValid;
   logic        ResultReady;
   logic        FrameErr;
   logic        Overrun;
   logic [15:0] FrameCnt;
   logic [7:0]  ErrCnt;

   int n_pass   = 0;
   int n_checks = 0;
   int fe_total = 0;
   int fe_snap;
   int seen;

   calc_result_receiver #(.SIZE(4), .WORD_W(16), .TIMEOUT_CYC(1024)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .RxEn        (RxEn),
      .DoutValid   (DoutValid),
      .DataOut     (DataOut),
      .ClkTx       (ClkTx),
      .Result      (Result),
      .ResultValid (ResultValid),
      .ResultReady (ResultReady),
      .FrameErr    (FrameErr),
      .Overrun     (Overrun),
      .FrameCnt    (FrameCnt),
      .ErrCnt      (ErrCnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(negedge Clk) if (FrameErr === 1'b1) fe_total++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One ClkTx pulse; returns on the falling Clk edge after the beat is sampled.
   task automatic beat(input logic [3:0] d, input logic v);
      @(negedge Clk);
      ClkTx = 1'b1; DataOut = d; DoutValid = v;
      @(negedge Clk);
      ClkTx = 1'b0;
   endtask

   task automatic send_beats(input logic [15:0] w, input int n);
      logic [15:0] sh;
      sh = w;
      for (int i = 0; i < n; i++) begin
         beat(sh[15:12], 1'b1);
         sh = sh << 4;
      end
   endtask

   task automatic drain();
      @(negedge Clk); ResultReady = 1'b1;
      @(negedge Clk); ResultReady = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; RxEn = 1'b1; DoutValid = 1'b0; DataOut = '0;
      ClkTx = 1'b0; ResultReady = 1'b0;
      #12;
      check("rst_result", 32'(Result), 32'h0);
      check("rst_valid", 32'(ResultValid), 32'h0);
      check("rst_frameerr", 32'(FrameErr), 32'h0);
      check("rst_overrun", 32'(Overrun), 32'h0);
      check("rst_framecnt", 32'(FrameCnt), 32'h0);
      check("rst_errcnt", 32'(ErrCnt), 32'h0);
      @(negedge Clk); Reset = 1'b1;

      // basic frame
      send_beats(16'hABCD, 3);
      check("basic_valid_early", 32'(ResultValid), 32'h0);
      beat(4'hD, 1'b1);
      check("basic_valid", 32'(ResultValid), 32'h1);
      check("basic_result", 32'(Result), 32'hABCD);
      check("basic_framecnt", 32'(FrameCnt), 32'd1);
      beat(4'h0, 1'b0);
      drain();
      check("basic_retired", 32'(ResultValid), 32'h0);

      // backpressure / overrun
      send_beats(16'h1234, 4);
      beat(4'h0, 1'b0);
      check("bp_first", 32'(Result), 32'h1234);
      send_beats(16'h5678, 4);
      check("bp_overrun", 32'(Overrun), 32'h1);
      check("bp_result_kept", 32'(Result), 32'h1234);
      check("bp_errcnt", 32'(ErrCnt), 32'd1);
      check("bp_framecnt", 32'(FrameCnt), 32'd2);
      beat(4'h0, 1'b0);
      check("bp_overrun_pulse", 32'(Overrun), 32'h0);
      drain();

      // short frame
      send_beats(16'hBE00, 2);
      beat(4'h0, 1'b0);
      check("short_frameerr", 32'(FrameErr), 32'h1);
      check("short_novalid", 32'(ResultValid), 32'h0);
      check("short_errcnt", 32'(ErrCnt), 32'd2);
      send_beats(16'hBEEF, 4);
      check("short_next_result", 32'(Result), 32'hBEEF);
      check("short_next_framecnt", 32'(FrameCnt), 32'd3);
      beat(4'h0, 1'b0);
      drain();

      // long frame
      fe_snap = fe_total;
      send_beats(16'h9A3C, 4);
      check("long_result", 32'(Result), 32'h9A3C);
      beat(4'hF, 1'b1);
      beat(4'hE, 1'b1);
      beat(4'h0, 1'b0);
      check("long_one_frameerr", 32'(fe_total - fe_snap), 32'd1);
      check("long_result_kept", 32'(Result), 32'h9A3C);
      check("long_errcnt", 32'(ErrCnt), 32'd3);
      check("long_framecnt", 32'(FrameCnt), 32'd4);
      drain();

      // timeout
      send_beats(16'h1200, 2);
      seen = 0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge Clk);
         if (FrameErr === 1'b1 && seen == 0) seen = i;
      end
      check("timeout_cycle", 32'(seen), 32'd1024);
      check("timeout_errcnt", 32'(ErrCnt), 32'd4);
      send_beats(16'h7E81, 4);
      check("timeout_next_result", 32'(Result), 32'h7E81);
      check("timeout_next_framecnt", 32'(FrameCnt), 32'd5);
      beat(4'h0, 1'b0);
      drain();

      // RxEn dropped mid-frame
      fe_snap = fe_total;
      send_beats(16'h3300, 2);
      @(negedge Clk); RxEn = 1'b0;
      repeat (3) @(negedge Clk);
      RxEn = 1'b1;
      send_beats(16'h4321, 4);
      check("rxen_result", 32'(Result), 32'h4321);
      check("rxen_framecnt", 32'(FrameCnt), 32'd6);
      check("rxen_no_frameerr", 32'(fe_total - fe_snap), 32'd0);
      check("rxen_errcnt", 32'(ErrCnt), 32'd4);
      beat(4'h0, 1'b0);
      drain();

      // accept and complete in the same cycle
      send_beats(16'h1111, 4);
      beat(4'h0, 1'b0);
      send_beats(16'h2220, 3);
      @(negedge Clk);
      ClkTx = 1'b1; DataOut = 4'h2; DoutValid = 1'b1; ResultReady = 1'b1;
      @(negedge Clk);
      ClkTx = 1'b0; ResultReady = 1'b0;
      check("b2b_result", 32'(Result), 32'h2222);
      check("b2b_valid", 32'(ResultValid), 32'h1);
      check("b2b_no_overrun", 32'(Overrun), 32'h0);
      check("b2b_framecnt", 32'(FrameCnt), 32'd8);
      check("b2b_errcnt", 32'(ErrCnt), 32'd4);
      beat(4'h0, 1'b0);
      drain();

      // reset mid-frame
      send_beats(16'h5A5A, 4);
      beat(4'h0, 1'b0);
      send_beats(16'h1200, 2);
      @(negedge Clk); Reset = 1'b0;
      #1;
      check("rstmid_result", 32'(Result), 32'h0);
      check("rstmid_valid", 32'(ResultValid), 32'h0);
      check("rstmid_framecnt", 32'(FrameCnt), 32'h0);
      check("rstmid_errcnt", 32'(ErrCnt), 32'h0);
      @(negedge Clk); Reset = 1'b1;
      send_beats(16'hC0DE, 4);
      check("rstmid_next_result", 32'(Result), 32'hC0DE);
      check("rstmid_next_framecnt", 32'(FrameCnt), 32'd1);
      beat(4'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
